rt_transmit: RTL
================

RT_TRANSMIT -- requirements
Module: rt_transmit

Interface
REQ-001 Parameter: ADDRESS, default 5'd1, remote-terminal address this block answers to.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; command word valid on cmd_word, parity flag on p_error.
REQ-005 cmd_word  input  16  received command word: [15:11] address, [10] T/R (1 = transmit), [9:5] subaddress, [4:0] word count.
REQ-006 p_error  input  1  parity error on the command word; sampled with start.
REQ-007 mem_we, mem_addr, mem_wdata  input  1/5/16  host write port into the internal 32x16 transmit buffer.
REQ-008 tx_done  input  1  one-cycle pulse from the encoder: the current word has been fully sent.
REQ-009 tx_data  output  16  word to transmit.
REQ-010 tx_cd  output  1  sync type: 1 = command/status sync, 0 = data sync.
REQ-011 tx_ready  output  1  tx_data/tx_cd valid; request to the encoder.
REQ-012 busy  output  1  high from accepted start until return to IDLE.
REQ-013 done  output  1  one-cycle pulse when the last word is acknowledged.
REQ-014 timeout_err  output  1  one-cycle pulse on encoder timeout.

Function
REQ-015 States: IDLE, DECODE, LOAD_OS, SEND_OS, FETCH, LOAD_DW, SEND_DW, FINISH.
REQ-016 IDLE: start with busy low -> DECODE; latch cmd_word; busy=1 next cycle.
REQ-017 start while busy is ignored.
REQ-018 DECODE: cmd[15:11] != ADDRESS, or cmd[10] = 0 -> IDLE; no output activity; busy drops the next cycle.
REQ-019 DECODE: p_error = 1 -> set sticky me_flag -> IDLE; no response sent.
REQ-020 DECODE, otherwise -> LOAD_OS; word_total = 32 if cmd[4:0] = 0, else cmd[4:0] (6-bit).
REQ-021 LOAD_OS: tx_data = {ADDRESS, me_flag, 10'd0}; tx_cd = 1; clear me_flag.
REQ-022 SEND_OS: hold tx_ready = 1 with tx_data/tx_cd stable until tx_done; on tx_done drop tx_ready the next cycle -> FETCH.
REQ-023 FETCH: drive read address rd_ptr (5-bit, starts at 0); the synchronous buffer read has 1-cycle latency.
REQ-024 LOAD_DW: tx_data = mem[rd_ptr]; tx_cd = 0.
REQ-025 SEND_DW: same handshake as SEND_OS; on tx_done, increment the sent counter.
REQ-026 SEND_DW, sent counter = word_total -> FINISH; otherwise increment rd_ptr -> FETCH.
REQ-027 rd_ptr wraps 31 -> 0; only reachable at count 32, after the last word.
REQ-028 FINISH: done = 1 for one cycle; clear counters and rd_ptr -> IDLE.
REQ-029 IDLE drives tx_ready = 0, tx_cd = 0 and tx_data = 0.
REQ-030 tx_done outside SEND_OS/SEND_DW is ignored.
REQ-031 Host writes are always accepted, including during transmission.
REQ-032 Same-cycle write and read of one address returns the old data.
REQ-033 Gap between tx_done and the next tx_ready is exactly 3 cycles: FETCH, LOAD_DW, then assert.

Reset
REQ-034 Reset applies immediately, including mid-message; state -> IDLE.
REQ-035 Reset values: tx_data = 0, tx_cd = 0, tx_ready = 0, busy = 0, done = 0, timeout_err = 0.
REQ-036 Reset also clears me_flag, rd_ptr, the counters and the timeout counter.
REQ-037 Buffer contents are not cleared by reset.

Configuration
REQ-038 Macro RT_TX_TIMEOUT_EN defined: a 12-bit counter runs while in SEND_OS/SEND_DW and restarts on entering each.
REQ-039 With RT_TX_TIMEOUT_EN, if the count reaches 4095 without tx_done: timeout_err pulses, tx_ready drops, state -> IDLE, done not asserted.
REQ-040 Without RT_TX_TIMEOUT_EN: SEND states wait indefinitely; timeout_err is tied to 0; no counter logic.

Verification
REQ-041 ADDRESS = 1; buffer preload mem[0..2] = 16'hA001/A002/A003; start with cmd 16'h0C03; tx_done issued 5 cycles after each tx_ready -> words 16'h0800 (tx_cd = 1), then A001, A002, A003 (tx_cd = 0); done pulses once; busy then falls.
REQ-042 cmd 16'h0C00 -> status word plus 32 data words mem[0..31] in order; done after the 32nd tx_done.
REQ-043 Commands ignored, with no tx_ready: cmd 16'h1403 (address 2) and cmd 16'h0803 (receive); busy is high for 2 cycles only.
REQ-044 cmd 16'h0C01 with p_error = 1 -> no response; then cmd 16'h0C01 clean -> status 16'h0C00 (ME set); a third command -> status 16'h0800.
REQ-045 Reset asserted mid-message after the 2nd data word -> all outputs 0 immediately; the next command restarts at mem[0].
REQ-046 With RT_TX_TIMEOUT_EN: never issue tx_done -> timeout_err pulses 4095 cycles after tx_ready rises; then IDLE with busy = 0.

Source files
------------

// File: rtl/rt_transmit.sv
// Remote-terminal transmit sequencer: answers a transmit command with a status word followed by data words from a 32x16 buffer.
// Optional encoder watchdog enabled by defining RT_TX_TIMEOUT_EN.
module rt_transmit #(
  parameter logic [4:0] ADDRESS = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] cmd_word,
  input  logic        p_error,
  input  logic        mem_we,
  input  logic [4:0]  mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        tx_done,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  output logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, DECODE, LOAD_OS, SEND_OS, FETCH, LOAD_DW, SEND_DW, FINISH
  } state_t;

  state_t      state;
  logic [4:0]  cmd_addr;
  logic        cmd_tr;
  logic [4:0]  cmd_wc;
  logic        perr_q;
  logic        me_flag;
  logic [5:0]  word_total;
  logic [5:0]  sent;
  logic [4:0]  rd_ptr;
  logic [15:0] mem [0:31];
  logic [15:0] rd_data;

  // Host write port and read port share one clock; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_data <= mem[rd_ptr];
  end

`ifdef RT_TX_TIMEOUT_EN
  logic [11:0] to_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_addr   <= '0;
      cmd_tr     <= 1'b0;
      cmd_wc     <= '0;
      perr_q     <= 1'b0;
      me_flag    <= 1'b0;
      word_total <= '0;
      sent       <= '0;
      rd_ptr     <= '0;
      tx_data    <= '0;
      tx_cd      <= 1'b0;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef RT_TX_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef RT_TX_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          tx_data  <= '0;
          tx_cd    <= 1'b0;
          tx_ready <= 1'b0;
          if (start && !busy) begin
            cmd_addr <= cmd_word[15:11];
            cmd_tr   <= cmd_word[10];
            cmd_wc   <= cmd_word[4:0];
            perr_q   <= p_error;
            busy     <= 1'b1;
            state    <= DECODE;
          end else begin
            busy <= 1'b0;
          end
        end
        DECODE: begin
          if (cmd_addr != ADDRESS || !cmd_tr) begin
            state <= IDLE;
          end else if (perr_q) begin
            me_flag <= 1'b1;
            state   <= IDLE;
          end else begin
            word_total <= (cmd_wc == 5'd0) ? 6'd32 : {1'b0, cmd_wc};
            state      <= LOAD_OS;
          end
        end
        LOAD_OS: begin
          tx_data  <= {ADDRESS, me_flag, 10'd0};
          tx_cd    <= 1'b1;
          tx_ready <= 1'b1;
          me_flag  <= 1'b0;
`ifdef RT_TX_TIMEOUT_EN
          to_cnt   <= '0;
`endif
          state    <= SEND_OS;
        end
        SEND_OS, SEND_DW: begin
          if (tx_done) begin
            tx_ready <= 1'b0;
            if (state == SEND_OS) begin
              state <= FETCH;
            end else if (sent + 6'd1 == word_total) begin
              sent  <= sent + 6'd1;
              state <= FINISH;
            end else begin
              sent   <= sent + 6'd1;
              rd_ptr <= rd_ptr + 5'd1;
              state  <= FETCH;
            end
          end
`ifdef RT_TX_TIMEOUT_EN
          // Count would reach 4095 on this edge: abort so timeout_err lands 4095 cycles after tx_ready rose.
          else if (to_cnt == 12'd4094) begin
            timeout_err <= 1'b1;
            tx_ready    <= 1'b0;
            tx_data     <= '0;
            tx_cd       <= 1'b0;
            sent        <= '0;
            rd_ptr      <= '0;
            to_cnt      <= '0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 12'd1;
          end
`endif
        end
        FETCH: begin
          state <= LOAD_DW;
        end
        LOAD_DW: begin
          tx_data  <= rd_data;
          tx_cd    <= 1'b0;
          tx_ready <= 1'b1;
`ifdef RT_TX_TIMEOUT_EN
          to_cnt   <= '0;
`endif
          state    <= SEND_DW;
        end
        FINISH: begin
          done    <= 1'b1;
          sent    <= '0;
          rd_ptr  <= '0;
          tx_data <= '0;
          tx_cd   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
